// File: rtl/fabric_rr_arbiter_if.sv
// Handshake bundle between the masters, the round-robin arbiter and the shared slave path.
// Latency: none, wires only.
// Backpressure: s_req_ready stalls the granted master; m_req held until accepted.
interface fabric_rr_arbiter_if #(
  parameter int M     = 4,
  parameter int IDX_W = (M <= 1) ? 1 : $clog2(M)
);
  logic [M-1:0]     m_req;
  logic [M-1:0]     m_lock;
  logic [M-1:0]     m_gnt;
  logic [M-1:0]     m_rsp_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             s_req_valid;
  logic             s_req_ready;
  logic             s_rsp_valid;
  logic             busy;
  logic             timeout;

  // Arbiter side: drives grants and the shared request.
  modport master (
    input  m_req, m_lock, s_req_ready, s_rsp_valid,
    output m_gnt, m_rsp_valid, gnt_idx, s_req_valid, busy, timeout
  );

  // Environment side: requesting masters plus the slave path.
  modport slave (
    output m_req, m_lock, s_req_ready, s_rsp_valid,
    input  m_gnt, m_rsp_valid, gnt_idx, s_req_valid, busy, timeout
  );
endinterface

// File: rtl/fabric_rr_arbiter.sv
// Round-robin arbiter sharing one fabric slave path among M masters, with lock and response watchdog.
// Latency: 1 cycle IDLE->REQ arbitration; an unlocked transaction takes at least 3 cycles.
// Backpressure: holds REQ while s_req_ready is low; a hung RSP is released by the watchdog.
module fabric_rr_arbiter #(
  parameter int M              = 4,
  parameter int IDX_W          = (M <= 1) ? 1 : $clog2(M),
  parameter int TIMEOUT_CYCLES = 256,
  parameter int LOCK_MAX       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  fabric_rr_arbiter_if.master bus
);

  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LK_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] ptr_next;
  logic             req_gnt;
  logic             lock_gnt;
  logic             lock_ok;
  logic             wd_expire;

  // First requester at or above ptr, wrapping mod M (works for non-power-of-2 M).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < M; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % M);
      if (!win_vld && bus.m_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign req_gnt   = bus.m_req[gnt_idx_q];
  assign lock_gnt  = bus.m_lock[gnt_idx_q];
  assign lock_ok   = (LOCK_MAX == 0) || (int'(lock_cnt_q) < LOCK_MAX - 1);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_LAST);
  assign ptr_next  = (int'(gnt_idx_q) == M - 1) ? '0 : gnt_idx_q + IDX_W'(1);

  // Next-state logic plus the state-dependent request/timeout strobes.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    wdog_d          = wdog_q;
    lock_cnt_d      = lock_cnt_q;
    bus.s_req_valid = 1'b0;
    bus.timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_idx_d = win_idx;
          state_d   = REQ;
        end
      end
      REQ: begin
        bus.s_req_valid = 1'b1;
        if (bus.s_req_ready) begin
          state_d = RSP;
          wdog_d  = '0;
        end else if (!req_gnt) begin
          // Master withdrew before acceptance: give up without moving ptr.
          state_d = IDLE;
        end
      end
      RSP: begin
        if (wdog_q != '1) begin
          wdog_d = wdog_q + WD_W'(1);
        end
        // A response arriving on the expiry cycle takes priority over the watchdog.
        if (bus.s_rsp_valid) begin
          if (lock_gnt && req_gnt && lock_ok) begin
            state_d = REQ;
            if (lock_cnt_q != '1) begin
              lock_cnt_d = lock_cnt_q + LK_W'(1);
            end
          end else begin
            state_d    = IDLE;
            ptr_d      = ptr_next;
            lock_cnt_d = '0;
          end
        end else if (wd_expire) begin
          bus.timeout = 1'b1;
          state_d     = IDLE;
          ptr_d       = ptr_next;
          lock_cnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, grant index and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      wdog_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      wdog_q     <= wdog_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // One-hot grant while busy; the slave response is routed only in RSP.
  always_comb begin
    bus.m_gnt       = '0;
    bus.m_rsp_valid = '0;
    for (int i = 0; i < M; i++) begin
      bus.m_gnt[i]       = (state_q != IDLE) && (gnt_idx_q == IDX_W'(i));
      bus.m_rsp_valid[i] = (state_q == RSP) && bus.s_rsp_valid && (gnt_idx_q == IDX_W'(i));
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_fabric_rr_arbiter.sv
// Directed-vector bench for fabric_rr_arbiter (M=4, TIMEOUT_CYCLES=4, LOCK_MAX=3).
// Latency: each vector row is one clock; inputs change on negedge, outputs sampled 2 units later.
// Backpressure: rows hold s_req_ready low to stall REQ where a stall is expected.
module tb_fabric_rr_arbiter;
  localparam int M     = 4;
  localparam int IDX_W = 2;
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_RSP  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fabric_rr_arbiter_if #(.M(M), .IDX_W(IDX_W)) bus ();

  fabric_rr_arbiter #(
    .M(M), .IDX_W(IDX_W), .TIMEOUT_CYCLES(4), .LOCK_MAX(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic       rdy;
    logic       rsp;
    logic [3:0] gnt;
    logic [3:0] mrv;
    logic [1:0] idx;
    logic       chk_idx;
    logic       sreq;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: inputs plus the hand-chosen state (IDLE/REQ/RSP) and granted index.
  task automatic row(input logic [3:0] req, input logic [3:0] lock, input logic rdy,
                     input logic rsp, input int st, input int idx, input logic to);
    vec_t v;
    v.req     = req;
    v.lock    = lock;
    v.rdy     = rdy;
    v.rsp     = rsp;
    v.gnt     = (st != S_IDLE) ? (4'b0001 << idx) : 4'b0000;
    v.mrv     = (st == S_RSP && rsp) ? (4'b0001 << idx) : 4'b0000;
    v.idx     = 2'(idx);
    v.chk_idx = (st != S_IDLE);
    v.sreq    = (st == S_REQ);
    v.busy    = (st != S_IDLE);
    v.to      = to;
    vecs.push_back(v);
  endtask

  // Unlocked 3-cycle transaction to idx; the stray rsp in IDLE must be ignored.
  task automatic txn(input logic [3:0] req, input logic [3:0] lock, input int idx);
    row(req, lock, 1'b0, 1'b1, S_IDLE, 0,   1'b0);
    row(req, lock, 1'b1, 1'b0, S_REQ,  idx, 1'b0);
    row(req, lock, 1'b0, 1'b1, S_RSP,  idx, 1'b0);
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d m_gnt", i),       32'(bus.m_gnt),       32'(v.gnt));
    chk($sformatf("v%0d m_rsp_valid", i), 32'(bus.m_rsp_valid), 32'(v.mrv));
    chk($sformatf("v%0d s_req_valid", i), 32'(bus.s_req_valid), 32'(v.sreq));
    chk($sformatf("v%0d busy", i),        32'(bus.busy),        32'(v.busy));
    chk($sformatf("v%0d timeout", i),     32'(bus.timeout),     32'(v.to));
    if (v.chk_idx) chk($sformatf("v%0d gnt_idx", i), 32'(bus.gnt_idx), 32'(v.idx));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " m_gnt"},       32'(bus.m_gnt),       32'h0);
    chk({tag, " m_rsp_valid"}, 32'(bus.m_rsp_valid), 32'h0);
    chk({tag, " gnt_idx"},     32'(bus.gnt_idx),     32'h0);
    chk({tag, " s_req_valid"}, 32'(bus.s_req_valid), 32'h0);
    chk({tag, " busy"},        32'(bus.busy),        32'h0);
    chk({tag, " timeout"},     32'(bus.timeout),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running");
    $fatal(1, "time limit reached");
  end

  initial begin
    // 1: masters 1 and 3 alternate from ptr=0.
    txn(4'b1010, 4'b0000, 1);
    txn(4'b1010, 4'b0000, 3);
    txn(4'b1010, 4'b0000, 1);
    txn(4'b1010, 4'b0000, 3);
    // 2: all requesting -> 0,1,2,3,0 (ptr ends at 1).
    txn(4'b1111, 4'b0000, 0);
    txn(4'b1111, 4'b0000, 1);
    txn(4'b1111, 4'b0000, 2);
    txn(4'b1111, 4'b0000, 3);
    txn(4'b1111, 4'b0000, 0);
    // 3: master 2 locked, LOCK_MAX=3 -> three back-to-back grants, then master 3.
    row(4'b1100, 4'b0100, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b1100, 4'b0100, 1'b1, 1'b0, S_REQ,  2, 1'b0);
    row(4'b1100, 4'b0100, 1'b0, 1'b1, S_RSP,  2, 1'b0);
    row(4'b1100, 4'b0100, 1'b1, 1'b0, S_REQ,  2, 1'b0);
    row(4'b1100, 4'b0100, 1'b0, 1'b1, S_RSP,  2, 1'b0);
    row(4'b1100, 4'b0100, 1'b1, 1'b0, S_REQ,  2, 1'b0);
    row(4'b1100, 4'b0100, 1'b0, 1'b1, S_RSP,  2, 1'b0);
    txn(4'b1100, 4'b0100, 3);
    // 4: slave hangs; timeout on 4th RSP cycle, then master 1 is granted.
    row(4'b0011, 4'b0000, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b0011, 4'b0000, 1'b1, 1'b0, S_REQ,  0, 1'b0);
    row(4'b0011, 4'b0000, 1'b0, 1'b0, S_RSP,  0, 1'b0);
    row(4'b0011, 4'b0000, 1'b0, 1'b0, S_RSP,  0, 1'b0);
    row(4'b0011, 4'b0000, 1'b0, 1'b0, S_RSP,  0, 1'b0);
    row(4'b0011, 4'b0000, 1'b0, 1'b0, S_RSP,  0, 1'b1);
    txn(4'b0011, 4'b0000, 1);
    // 5a: response on the expiry cycle wins, no timeout.
    row(4'b0100, 4'b0000, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b0100, 4'b0000, 1'b1, 1'b0, S_REQ,  2, 1'b0);
    row(4'b0100, 4'b0000, 1'b0, 1'b0, S_RSP,  2, 1'b0);
    row(4'b0100, 4'b0000, 1'b0, 1'b0, S_RSP,  2, 1'b0);
    row(4'b0100, 4'b0000, 1'b0, 1'b0, S_RSP,  2, 1'b0);
    row(4'b0100, 4'b0000, 1'b0, 1'b1, S_RSP,  2, 1'b0);
    // 5b: stalled REQ, master 3 aborts; ptr stays 3 so master 3 beats master 0.
    row(4'b1000, 4'b0000, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b1000, 4'b0000, 1'b0, 1'b0, S_REQ,  3, 1'b0);
    row(4'b1000, 4'b0000, 1'b0, 1'b0, S_REQ,  3, 1'b0);
    row(4'b0000, 4'b0000, 1'b0, 1'b0, S_REQ,  3, 1'b0);
    row(4'b1001, 4'b0000, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b1001, 4'b0000, 1'b1, 1'b0, S_REQ,  3, 1'b0);
    row(4'b1001, 4'b0000, 1'b0, 1'b1, S_RSP,  3, 1'b0);
    // Lock honoured once, then m_req dropped at the response releases the grant.
    row(4'b0001, 4'b0001, 1'b0, 1'b0, S_IDLE, 0, 1'b0);
    row(4'b0001, 4'b0001, 1'b1, 1'b0, S_REQ,  0, 1'b0);
    row(4'b0001, 4'b0001, 1'b0, 1'b1, S_RSP,  0, 1'b0);
    row(4'b0001, 4'b0001, 1'b1, 1'b0, S_REQ,  0, 1'b0);
    row(4'b0000, 4'b0001, 1'b0, 1'b1, S_RSP,  0, 1'b0);
    row(4'b0000, 4'b0000, 1'b0, 1'b0, S_IDLE, 0, 1'b0);

    // Reset state with inputs active.
    bus.m_req       = 4'b1111;
    bus.m_lock      = 4'b0000;
    bus.s_req_ready = 1'b1;
    bus.s_rsp_valid = 1'b1;
    rst_n           = 1'b1;
    #1 rst_n        = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    bus.m_req       = 4'b0000;
    bus.s_req_ready = 1'b0;
    bus.s_rsp_valid = 1'b0;
    rst_n           = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.m_req       = vecs[i].req;
      bus.m_lock      = vecs[i].lock;
      bus.s_req_ready = vecs[i].rdy;
      bus.s_rsp_valid = vecs[i].rsp;
      #2;
      check_vec(i, vecs[i]);
    end

    // 6: async reset mid-RSP (ptr is 1 here), then first grant from index 0.
    @(negedge clk);
    bus.m_req       = 4'b0100;
    bus.m_lock      = 4'b0000;
    bus.s_req_ready = 1'b0;
    bus.s_rsp_valid = 1'b0;
    @(negedge clk);
    bus.s_req_ready = 1'b1;
    @(negedge clk);
    bus.s_req_ready = 1'b0;
    #2;
    chk("pre_reset m_gnt", 32'(bus.m_gnt), 32'h4);
    bus.s_rsp_valid = 1'b1;
    rst_n           = 1'b0;
    #1;
    check_all_zero("mid_rsp_reset");
    @(negedge clk);
    rst_n           = 1'b1;
    bus.s_rsp_valid = 1'b0;
    bus.m_req       = 4'b0101;
    #2;
    chk("post_reset busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    #2;
    chk("post_reset m_gnt", 32'(bus.m_gnt), 32'h1);
    chk("post_reset gnt_idx", 32'(bus.gnt_idx), 32'h0);
    chk("post_reset s_req_valid", 32'(bus.s_req_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
